mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage: consumes the EX/MEM latch outputs, performs data-memory
//  load/store over a req/ack handshake of variable latency, resolves branches
//  from condition select + ALU flags, and drives registered MEM/WB results.
//  Sits between the EX/MEM latch and the MEM/WB latch; stalls upstream while busy.
// PARAMETERS
//  DW       32   data/address width
//  RDW      4    destination register index width
//  SIGW     11   control-signal bundle width
//  TIMEOUT  64   max cycles waiting for dmem_ack before abort (>=2)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  ex_valid     in   1     EX/MEM entry holds a real instruction (0 = bubble)
//  ex_br        in   4     branch condition select
//  ex_alu_cond  in   4     ALU flags {N,Z,C,V}
//  ex_alu       in   DW    ALU result; memory address for ld/st
//  ex_adder     in   DW    branch target
//  ex_wdata     in   DW    store data
//  ex_rd        in   RDW   destination register
//  ex_signals   in   SIGW  control: [0]mem_read [1]mem_write [2]reg_write [3]branch
//  stall_ex     out  1     hold EX/MEM latch and earlier stages
//  dmem_req     out  1     memory request
//  dmem_we      out  1     1 = store
//  dmem_addr    out  DW    word-aligned address
//  dmem_wdata   out  DW    store data
//  dmem_ack     in   1     request complete (load data valid same cycle)
//  dmem_rdata   in   DW    load data
//  wb_valid     out  1     MEM/WB result valid this cycle
//  wb_data      out  DW    load data or ALU result
//  wb_rd        out  RDW   destination register
//  wb_reg_write out  1     write-back enable
//  br_taken     out  1     one-cycle pulse: branch taken
//  br_target    out  DW    target, valid with br_taken
//  mem_err      out  1     one-cycle pulse: misaligned access or timeout
// BEHAVIOUR
//  - Reset (async): state IDLE, all outputs 0, timeout counter 0. Reset during
//    BUSY drops dmem_req immediately; the transaction is abandoned.
//  - States: IDLE, BUSY.
//  - IDLE, ex_valid=0: wb_valid=0, br_taken=0 next cycle; stall_ex=0.
//  - IDLE, ex_valid=1, no mem op: next edge registers wb_valid=1,
//    wb_data=ex_alu, wb_rd, wb_reg_write; latency 1 cycle.
//  - IDLE, ex_valid=1, mem op, ex_alu[1:0]!=0: no request; next edge pulses
//    mem_err, wb_valid=0.
//  - IDLE, ex_valid=1, aligned mem op: dmem_req=1 registered next edge with
//    addr/wdata/we captured; go BUSY. stall_ex is combinational 1 from that
//    cycle until the ack cycle inclusive.
//  - Both mem_read and mem_write set: treated as store.
//  - BUSY: req/addr/we/wdata held stable until dmem_ack. On ack: req drops next
//    edge, wb_valid=1, wb_data=dmem_rdata (load) or captured ex_alu (store,
//    wb_reg_write forced 0); back to IDLE. Min load latency 2 cycles.
//  - Timeout: counter increments each BUSY cycle; reaching TIMEOUT-1 without
//    ack -> drop req, pulse mem_err, wb_valid=0, IDLE. Late ack in IDLE ignored.
//  - Branch: when ex_valid & signals[3], evaluated in the cycle the result is
//    registered (same edge as wb_valid). br codes: 0 EQ(Z) 1 NE(!Z)
//    2 LT(N^V) 3 GE(!(N^V)) 4 CS(C) 5 CC(!C) 6 AL; 7-15 never.
//    br_taken/br_target registered; br_taken is a 1-cycle pulse.
//  - wb_valid/br_taken/mem_err are pulses; wb_data/wb_rd hold until next update.
// STRUCTURE
//  - mem_pkg: signal-bit indices, branch condition codes, state encoding,
//    flag bit positions.
//  - Sub-module br_cond_unit: combinational (cond[3:0], flags[3:0]) -> taken.
//  - Top: FSM, timeout counter, request and output registers.
// TESTING
//  1 ALU op: ex_alu=0x1234, rd=5, reg_write -> 1 cycle later wb_valid=1,
//    wb_data=0x1234, wb_rd=5, stall_ex=0.
//  2 Load addr 0x100, ack after 3 cycles, rdata=0xDEADBEEF -> req held 3 cycles,
//    stall_ex high through ack, wb_data=0xDEADBEEF.
//  3 Store addr 0x102 -> no dmem_req, mem_err pulse, wb_valid=0.
//  4 TIMEOUT=4, load never acked -> req drops after 4 cycles, mem_err pulse,
//    IDLE; later stray ack ignored.
//  5 Branch br=0, flags Z=1, adder=0x40 -> br_taken pulse, br_target=0x40;
//    br=1, same flags -> br_taken=0; br=9 -> never taken.
//  6 Assert reset in BUSY -> dmem_req, stall_ex, all outputs 0 immediately,
//    state IDLE; next ALU op completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit positions,
// ALU flag positions, branch condition codes and FSM state encoding.
package mem_pkg;

    localparam int unsigned SIG_MEM_READ  = 0;
    localparam int unsigned SIG_MEM_WRITE = 1;
    localparam int unsigned SIG_REG_WRITE = 2;
    localparam int unsigned SIG_BRANCH    = 3;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned COND_W = 4;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [COND_W-1:0] {
        BR_EQ = 4'd0,
        BR_NE = 4'd1,
        BR_LT = 4'd2,
        BR_GE = 4'd3,
        BR_CS = 4'd4,
        BR_CC = 4'd5,
        BR_AL = 4'd6
    } br_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_br_cond_unit.sv
// Branch condition evaluator: condition select plus {N,Z,C,V} flags -> taken.
module br_cond_unit
    import mem_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            BR_EQ:   taken_c = flags[FLAG_Z];
            BR_NE:   taken_c = ~flags[FLAG_Z];
            BR_LT:   taken_c = flags[FLAG_N] ^ flags[FLAG_V];
            BR_GE:   taken_c = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            BR_CS:   taken_c = flags[FLAG_C];
            BR_CC:   taken_c = ~flags[FLAG_C];
            BR_AL:   taken_c = 1'b1;
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory load/store over req/ack with timeout,
// branch resolution, and registered MEM/WB results.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned RDW     = 4,
    parameter int unsigned SIGW    = 11,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [3:0]      ex_br,
    input  logic [3:0]      ex_alu_cond,
    input  logic [DW-1:0]   ex_alu,
    input  logic [DW-1:0]   ex_adder,
    input  logic [DW-1:0]   ex_wdata,
    input  logic [RDW-1:0]  ex_rd,
    input  logic [SIGW-1:0] ex_signals,
    output logic            stall_ex,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic            dmem_ack,
    input  logic [DW-1:0]   dmem_rdata,
    output logic            wb_valid,
    output logic [DW-1:0]   wb_data,
    output logic [RDW-1:0]  wb_rd,
    output logic            wb_reg_write,
    output logic            br_taken,
    output logic [DW-1:0]   br_target,
    output logic            mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           req_nx, we_nx;
    logic [DW-1:0]  addr_nx, wdata_nx;
    logic           wb_valid_nx, wb_rw_nx, br_taken_nx, mem_err_nx;
    logic [DW-1:0]  wb_data_nx, br_target_nx;
    logic [RDW-1:0] wb_rd_nx;
    logic           stall_c;

    // Instruction context held while the memory access is in flight
    logic           cap_load, cap_rw, cap_br;
    logic [RDW-1:0] cap_rd;
    logic [DW-1:0]  cap_tgt;
    logic           cap_load_nx, cap_rw_nx, cap_br_nx;
    logic [RDW-1:0] cap_rd_nx;
    logic [DW-1:0]  cap_tgt_nx;

    logic mem_read, mem_write, reg_write, is_branch, mem_op, aligned, cond_taken;
    logic unused_sig;

    assign mem_read   = ex_signals[SIG_MEM_READ];
    assign mem_write  = ex_signals[SIG_MEM_WRITE];
    assign reg_write  = ex_signals[SIG_REG_WRITE];
    assign is_branch  = ex_signals[SIG_BRANCH];
    assign mem_op     = mem_read | mem_write;
    assign aligned    = (ex_alu[1:0] == 2'b00);
    assign unused_sig = ^ex_signals;

    br_cond_unit u_br_cond (
        .cond    (ex_br),
        .flags   (ex_alu_cond),
        .taken_c (cond_taken)
    );

    // Reset must kill the stall immediately, even with a mem op still presented
    assign stall_ex = stall_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        stall_c      = 1'b0;
        cnt_nx       = cnt;
        req_nx       = dmem_req;
        we_nx        = dmem_we;
        addr_nx      = dmem_addr;
        wdata_nx     = dmem_wdata;
        wb_valid_nx  = 1'b0;
        wb_data_nx   = wb_data;
        wb_rd_nx     = wb_rd;
        wb_rw_nx     = wb_reg_write;
        br_taken_nx  = 1'b0;
        br_target_nx = br_target;
        mem_err_nx   = 1'b0;
        cap_load_nx  = cap_load;
        cap_rw_nx    = cap_rw;
        cap_br_nx    = cap_br;
        cap_rd_nx    = cap_rd;
        cap_tgt_nx   = cap_tgt;

        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        wb_valid_nx = 1'b1;
                        wb_data_nx  = ex_alu;
                        wb_rd_nx    = ex_rd;
                        wb_rw_nx    = reg_write;
                        br_taken_nx = is_branch & cond_taken;
                        if (is_branch & cond_taken) br_target_nx = ex_adder;
                    end else if (!aligned) begin
                        mem_err_nx = 1'b1;
                    end else begin
                        stall_c     = 1'b1;
                        state_nx    = BUSY;
                        cnt_nx      = '0;
                        req_nx      = 1'b1;
                        we_nx       = mem_write;
                        addr_nx     = ex_alu;
                        wdata_nx    = ex_wdata;
                        cap_load_nx = ~mem_write;
                        cap_rw_nx   = reg_write & ~mem_write;
                        cap_br_nx   = is_branch & cond_taken;
                        cap_rd_nx   = ex_rd;
                        cap_tgt_nx  = ex_adder;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    req_nx      = 1'b0;
                    we_nx       = 1'b0;
                    wb_valid_nx = 1'b1;
                    wb_data_nx  = cap_load ? dmem_rdata : dmem_addr;
                    wb_rd_nx    = cap_rd;
                    wb_rw_nx    = cap_rw;
                    br_taken_nx = cap_br;
                    if (cap_br) br_target_nx = cap_tgt;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    req_nx     = 1'b0;
                    we_nx      = 1'b0;
                    mem_err_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            br_taken     <= 1'b0;
            br_target    <= '0;
            mem_err      <= 1'b0;
            cap_load     <= 1'b0;
            cap_rw       <= 1'b0;
            cap_br       <= 1'b0;
            cap_rd       <= '0;
            cap_tgt      <= '0;
        end else begin
            cnt          <= cnt_nx;
            dmem_req     <= req_nx;
            dmem_we      <= we_nx;
            dmem_addr    <= addr_nx;
            dmem_wdata   <= wdata_nx;
            wb_valid     <= wb_valid_nx;
            wb_data      <= wb_data_nx;
            wb_rd        <= wb_rd_nx;
            wb_reg_write <= wb_rw_nx;
            br_taken     <= br_taken_nx;
            br_target    <= br_target_nx;
            mem_err      <= mem_err_nx;
            cap_load     <= cap_load_nx;
            cap_rw       <= cap_rw_nx;
            cap_br       <= cap_br_nx;
            cap_rd       <= cap_rd_nx;
            cap_tgt      <= cap_tgt_nx;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a behavioural model.
module tb_mem_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned RDW  = 4;
    localparam int unsigned SIGW = 11;
    localparam int unsigned TO   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid;
    logic [3:0]      ex_br, ex_alu_cond;
    logic [DW-1:0]   ex_alu, ex_adder, ex_wdata;
    logic [RDW-1:0]  ex_rd;
    logic [SIGW-1:0] ex_signals;
    logic            stall_ex, dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic            wb_valid, wb_reg_write, br_taken, mem_err;
    logic [DW-1:0]   wb_data, br_target;
    logic [RDW-1:0]  wb_rd;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0]  last_data;
    logic [RDW-1:0] last_rd;

    mem_stage #(.DW(DW), .RDW(RDW), .SIGW(SIGW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_br(ex_br),
        .ex_alu_cond(ex_alu_cond), .ex_alu(ex_alu), .ex_adder(ex_adder),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_signals(ex_signals),
        .stall_ex(stall_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .br_taken(br_taken),
        .br_target(br_target), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Branch truth table written from the condition definitions, flags {N,Z,C,V}
    function automatic logic br_ref(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return n != v;
            4'd3:    return n == v;
            4'd4:    return c;
            4'd5:    return !c;
            4'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; ex_br = '0; ex_alu_cond = '0; ex_alu = '0;
        ex_adder = '0; ex_wdata = '0; ex_rd = '0; ex_signals = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL reset_req act=%b exp=0", dmem_req); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid act=%b exp=0", wb_valid); else n_pass++;
        n_total++; if (wb_data !== '0) $display("FAIL reset_wb_data act=%h exp=0", wb_data); else n_pass++;
        n_total++; if ({br_taken, mem_err, stall_ex, wb_reg_write} !== 4'b0)
            $display("FAIL reset_flags act=%b exp=0000", {br_taken, mem_err, stall_ex, wb_reg_write}); else n_pass++;
        @(negedge clk); reset = 1'b0;
        last_data = '0; last_rd = '0;
    endtask

    task automatic test_alu();
        logic [DW-1:0] a; logic [RDW-1:0] rd; logic rw, bre, exp_br;
        for (int i = 0; i < 16; i++) begin
            a  = (i == 0) ? 32'h1234 : $urandom;
            rd = (i == 0) ? 4'd5 : RDW'($urandom);
            rw = (i == 0) ? 1'b1 : 1'($urandom);
            bre = (i == 0) ? 1'b0 : 1'($urandom);
            @(negedge clk);
            ex_valid = 1'b1; ex_alu = a; ex_rd = rd; ex_adder = $urandom;
            ex_br = 4'($urandom); ex_alu_cond = 4'($urandom);
            ex_signals = SIGW'($urandom); ex_signals[0] = 1'b0; ex_signals[1] = 1'b0;
            ex_signals[2] = rw; ex_signals[3] = bre;
            exp_br = bre & br_ref(ex_br, ex_alu_cond);
            #1;
            n_total++; if (stall_ex !== 1'b0) $display("FAIL alu_stall i=%0d act=%b exp=0", i, stall_ex); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid i=%0d act=%b exp=1", i, wb_valid); else n_pass++;
            n_total++; if (wb_data !== a) $display("FAIL alu_wb_data i=%0d act=%h exp=%h", i, wb_data, a); else n_pass++;
            n_total++; if (wb_rd !== rd || wb_reg_write !== rw)
                $display("FAIL alu_wb_rd i=%0d act=%0d/%b exp=%0d/%b", i, wb_rd, wb_reg_write, rd, rw); else n_pass++;
            n_total++; if (br_taken !== exp_br) $display("FAIL alu_br_taken i=%0d act=%b exp=%b", i, br_taken, exp_br); else n_pass++;
            if (exp_br) begin
                n_total++; if (br_target !== ex_adder) $display("FAIL alu_br_target i=%0d act=%h exp=%h", i, br_target, ex_adder); else n_pass++;
            end
            last_data = a; last_rd = rd;
        end
        @(negedge clk); ex_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if (wb_valid !== 1'b0 || br_taken !== 1'b0) $display("FAIL bubble_pulse act=%b%b exp=00", wb_valid, br_taken); else n_pass++;
        n_total++; if (wb_data !== last_data || wb_rd !== last_rd)
            $display("FAIL bubble_hold act=%h/%0d exp=%h/%0d", wb_data, wb_rd, last_data, last_rd); else n_pass++;
    endtask

    task automatic test_branch();
        logic [3:0] codes [3];
        logic [3:0] c; logic exp_br;
        codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd9;
        for (int i = 0; i < 19; i++) begin
            c = (i < 3) ? codes[i] : 4'($urandom);
            @(negedge clk);
            ex_valid = 1'b1; ex_signals = 11'b1000; ex_br = c; ex_alu = $urandom; ex_rd = 4'($urandom);
            ex_alu_cond = (i < 3) ? 4'b0100 : 4'($urandom);
            ex_adder = (i < 3) ? 32'h40 : $urandom;
            exp_br = br_ref(c, ex_alu_cond);
            @(posedge clk); #1;
            n_total++; if (br_taken !== exp_br) $display("FAIL br_taken i=%0d code=%0d act=%b exp=%b", i, c, br_taken, exp_br); else n_pass++;
            if (exp_br) begin
                n_total++; if (br_target !== ex_adder) $display("FAIL br_target i=%0d act=%h exp=%h", i, br_target, ex_adder); else n_pass++;
            end
            if (i == 0) begin
                @(negedge clk); ex_valid = 1'b0;
                @(posedge clk); #1;
                n_total++; if (br_taken !== 1'b0) $display("FAIL br_pulse act=%b exp=0", br_taken); else n_pass++;
            end
        end
        @(negedge clk); ex_valid = 1'b0;
    endtask

    task automatic test_mem();
        logic [DW-1:0] addr, wd, rdat, exp_data; logic [RDW-1:0] rd;
        logic st, rw, exp_rw; int lat;
        for (int i = 0; i < 10; i++) begin
            addr = (i == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
            rdat = (i == 0) ? 32'hDEADBEEF : $urandom;
            lat  = (i == 0) ? 3 : int'($urandom_range(1, TO));
            st   = (i == 0) ? 1'b0 : 1'($urandom);
            rw = 1'($urandom); rd = RDW'($urandom); wd = $urandom;
            @(negedge clk);
            ex_valid = 1'b1; ex_alu = addr; ex_wdata = wd; ex_rd = rd; ex_br = 4'd6;
            ex_signals = '0; ex_signals[2] = rw; ex_signals[1] = st;
            ex_signals[0] = st ? 1'($urandom) : 1'b1;
            exp_data = st ? addr : rdat;
            exp_rw   = st ? 1'b0 : rw;
            #1;
            n_total++; if (stall_ex !== 1'b1 || dmem_req !== 1'b0)
                $display("FAIL mem_issue i=%0d stall/req act=%b%b exp=10", i, stall_ex, dmem_req); else n_pass++;
            for (int c = 1; c <= lat; c++) begin
                @(posedge clk); #1;
                n_total++; if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== addr)
                    $display("FAIL mem_req i=%0d c=%0d act=%b/%b/%h exp=1/%b/%h", i, c, dmem_req, dmem_we, dmem_addr, st, addr); else n_pass++;
                n_total++; if (stall_ex !== 1'b1 || wb_valid !== 1'b0)
                    $display("FAIL mem_busy i=%0d c=%0d stall/wb act=%b%b exp=10", i, c, stall_ex, wb_valid); else n_pass++;
                if (st) begin
                    n_total++; if (dmem_wdata !== wd) $display("FAIL mem_wdata i=%0d act=%h exp=%h", i, dmem_wdata, wd); else n_pass++;
                end
            end
            @(negedge clk); dmem_ack = 1'b1; dmem_rdata = rdat; #1;
            n_total++; if (stall_ex !== 1'b1) $display("FAIL mem_ack_stall i=%0d act=%b exp=1", i, stall_ex); else n_pass++;
            @(posedge clk); #1; ex_valid = 1'b0; dmem_ack = 1'b0; #1;
            n_total++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || stall_ex !== 1'b0)
                $display("FAIL mem_done i=%0d req/wb/stall act=%b%b%b exp=010", i, dmem_req, wb_valid, stall_ex); else n_pass++;
            n_total++; if (wb_data !== exp_data || wb_rd !== rd || wb_reg_write !== exp_rw)
                $display("FAIL mem_result i=%0d act=%h/%0d/%b exp=%h/%0d/%b", i, wb_data, wb_rd, wb_reg_write, exp_data, rd, exp_rw); else n_pass++;
            n_total++; if (br_taken !== 1'b0) $display("FAIL mem_br i=%0d act=%b exp=0", i, br_taken); else n_pass++;
            last_data = exp_data; last_rd = rd;
        end
        @(posedge clk); #1;
        n_total++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) $display("FAIL mem_after act=%b%b exp=00", wb_valid, dmem_req); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [DW-1:0] addr;
        for (int i = 0; i < 6; i++) begin
            addr = (i == 0) ? 32'h102 : (($urandom & 32'hFFFF_FFFC) | DW'($urandom_range(1, 3)));
            @(negedge clk);
            ex_valid = 1'b1; ex_alu = addr; ex_rd = 4'($urandom); ex_signals = '0;
            ex_signals[1] = (i == 0) ? 1'b1 : 1'($urandom);
            ex_signals[0] = ~ex_signals[1] | 1'($urandom);
            #1;
            n_total++; if (stall_ex !== 1'b0) $display("FAIL mis_stall i=%0d act=%b exp=0", i, stall_ex); else n_pass++;
            @(posedge clk); #1; ex_valid = 1'b0;
            n_total++; if (mem_err !== 1'b1 || wb_valid !== 1'b0 || dmem_req !== 1'b0)
                $display("FAIL mis_err i=%0d err/wb/req act=%b%b%b exp=100", i, mem_err, wb_valid, dmem_req); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (mem_err !== 1'b0 || dmem_req !== 1'b0) $display("FAIL mis_pulse i=%0d act=%b%b exp=00", i, mem_err, dmem_req); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ex_valid = 1'b1; ex_alu = 32'h200; ex_signals = 11'b101; ex_rd = 4'd3;
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge clk); #1;
            n_total++; if (dmem_req !== 1'b1 || mem_err !== 1'b0)
                $display("FAIL to_wait c=%0d req/err act=%b%b exp=10", c, dmem_req, mem_err); else n_pass++;
        end
        @(posedge clk); #1; ex_valid = 1'b0; #1;
        n_total++; if (dmem_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b0 || stall_ex !== 1'b0)
            $display("FAIL to_abort req/err/wb/stall act=%b%b%b%b exp=0100", dmem_req, mem_err, wb_valid, stall_ex); else n_pass++;
        @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1; dmem_ack = 1'b0;
        n_total++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || mem_err !== 1'b0 || wb_data !== last_data)
            $display("FAIL to_stray_ack wb/req/err act=%b%b%b data=%h exp=000 data=%h", wb_valid, dmem_req, mem_err, wb_data, last_data); else n_pass++;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        ex_valid = 1'b1; ex_alu = 32'h300; ex_signals = 11'b101; ex_rd = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        n_total++; if (dmem_req !== 1'b0 || stall_ex !== 1'b0)
            $display("FAIL rstbusy_req/stall act=%b%b exp=00", dmem_req, stall_ex); else n_pass++;
        n_total++; if (wb_data !== '0 || wb_rd !== '0 || dmem_addr !== '0 || br_target !== '0)
            $display("FAIL rstbusy_outs act=%h/%0d/%h/%h exp=0", wb_data, wb_rd, dmem_addr, br_target); else n_pass++;
        ex_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        ex_valid = 1'b1; ex_alu = 32'hCAFE; ex_rd = 4'd9; ex_signals = 11'b100;
        @(posedge clk); #1; ex_valid = 1'b0;
        n_total++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE || wb_rd !== 4'd9 || dmem_req !== 1'b0)
            $display("FAIL rstbusy_next act=%b/%h/%0d/%b exp=1/cafe/9/0", wb_valid, wb_data, wb_rd, dmem_req); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
